// File: rtl/instr_encoder_if.sv
// Valid/ready bus between a field-level instruction source and the encoder.
// The master drives requests and out_ready; the slave (encoder) returns the packed words.
interface instr_encoder_if #(
   parameter int ADDR_W    = 32,
   parameter int ERR_CNT_W = 8
);
   logic                 start;
   logic                 in_valid;
   logic                 in_ready;
   logic [2:0]           in_fmt;
   logic [6:0]           in_opcode;
   logic [4:0]           in_rd;
   logic [4:0]           in_rs1;
   logic [4:0]           in_rs2;
   logic [2:0]           in_funct3;
   logic [6:0]           in_funct7;
   logic [31:0]          in_imm;
   logic                 out_valid;
   logic                 out_ready;
   logic [31:0]          out_instr;
   logic                 out_err;
   logic [ADDR_W-1:0]    out_addr;
   logic [ERR_CNT_W-1:0] err_count;

   modport master (
      output start, in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
             in_funct3, in_funct7, in_imm, out_ready,
      input  in_ready, out_valid, out_instr, out_err, out_addr, err_count
   );

   modport slave (
      input  start, in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
             in_funct3, in_funct7, in_imm, out_ready,
      output in_ready, out_valid, out_instr, out_err, out_addr, err_count
   );
endinterface

// File: rtl/instr_encoder.sv
// Packs a field-level RV32I instruction description into its 32-bit word.
// Two-stage valid/ready pipeline with range-error flag, word address and error counter.
module instr_encoder #(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   parameter int                ERR_CNT_W = 8
) (
   input logic            clk,
   input logic            rst,
   instr_encoder_if.slave bus
);

   logic                 s1Valid_q;
   logic [31:0]          s1Instr_q;
   logic                 s1Err_q;
   logic                 outValid_q;
   logic [31:0]          outInstr_q;
   logic                 outErr_q;
   logic [ADDR_W-1:0]    addr_q;
   logic [ADDR_W-1:0]    addr_d;
   logic [ERR_CNT_W-1:0] errCnt_q;
   logic [ERR_CNT_W-1:0] errCnt_d;

   logic        s2Free;
   logic        inReady;
   logic        accept;
   logic        move;
   logic        outFire;
   logic [31:0] packWord;
   logic        packErr;
   logic [31:0] imm;

   assign s2Free  = !outValid_q || bus.out_ready;
   assign inReady = !s1Valid_q || s2Free;
   assign accept  = bus.in_valid && inReady;
   assign move    = s1Valid_q && s2Free;
   assign outFire = outValid_q && bus.out_ready;
   assign imm     = bus.in_imm;

   // An immediate fits a field when every bit above the field's sign bit equals it.
   always_comb begin
      packWord = 32'h0;
      packErr  = 1'b0;
      case (bus.in_fmt)
         3'd0: begin
            packWord = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3,
                        bus.in_rd, bus.in_opcode};
         end
         3'd1: begin
            packWord = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
            packErr  = !((&imm[31:11]) || !(|imm[31:11]));
         end
         3'd2: begin
            packWord = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                        imm[4:0], bus.in_opcode};
            packErr  = !((&imm[31:11]) || !(|imm[31:11]));
         end
         3'd3: begin
            packWord = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                        imm[4:1], imm[11], bus.in_opcode};
            packErr  = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
         end
         3'd4: begin
            packWord = {imm[31:12], bus.in_rd, bus.in_opcode};
            packErr  = |imm[11:0];
         end
         3'd5: begin
            packWord = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, bus.in_opcode};
            packErr  = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
         end
         default: begin
            packWord = 32'h0000_0013;
            packErr  = 1'b1;
         end
      endcase
   end

   // start wins over a coincident handshake, so that word's error is never counted.
   always_comb begin
      addr_d   = addr_q;
      errCnt_d = errCnt_q;
      if (bus.start) begin
         addr_d   = BASE_ADDR;
         errCnt_d = '0;
      end else if (outFire) begin
         addr_d = addr_q + ADDR_W'(4);
         if (outErr_q && !(&errCnt_q)) begin
            errCnt_d = errCnt_q + ERR_CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1Valid_q  <= 1'b0;
         s1Instr_q  <= 32'h0;
         s1Err_q    <= 1'b0;
         outValid_q <= 1'b0;
         outInstr_q <= 32'h0;
         outErr_q   <= 1'b0;
         addr_q     <= BASE_ADDR;
         errCnt_q   <= '0;
      end else begin
         if (accept) begin
            s1Valid_q <= 1'b1;
            s1Instr_q <= packWord;
            s1Err_q   <= packErr;
         end else if (move) begin
            s1Valid_q <= 1'b0;
         end

         if (move) begin
            outValid_q <= 1'b1;
            outInstr_q <= s1Instr_q;
            outErr_q   <= s1Err_q;
         end else if (outFire) begin
            outValid_q <= 1'b0;
         end

         addr_q   <= addr_d;
         errCnt_q <= errCnt_d;
      end
   end

   assign bus.in_ready  = inReady;
   assign bus.out_valid = outValid_q;
   assign bus.out_instr = outInstr_q;
   assign bus.out_err   = outErr_q;
   assign bus.out_addr  = addr_q;
   assign bus.err_count = errCnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: hand-packed words, error flags, addressing,
// backpressure, start/handshake collision, counter saturation and mid-stream reset.
module tb_instr_encoder;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   instr_encoder_if #(.ADDR_W(32), .ERR_CNT_W(8)) bus ();

   instr_encoder #(
      .ADDR_W    (32),
      .BASE_ADDR (32'h0),
      .ERR_CNT_W (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives one request onto the input side and raises in_valid.
   task automatic applyStimulus(input logic [2:0] fmt, input logic [6:0] op,
                                input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [31:0] imm);
      bus.in_fmt    = fmt;
      bus.in_opcode = op;
      bus.in_rd     = rd;
      bus.in_rs1    = rs1;
      bus.in_rs2    = rs2;
      bus.in_funct3 = f3;
      bus.in_funct7 = f7;
      bus.in_imm    = imm;
      bus.in_valid  = 1'b1;
   endtask

   task automatic idle();
      bus.in_valid = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic checkWord(input string tag, input logic [31:0] instr,
                            input logic err, input logic [31:0] addr);
      checkOutput({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
      checkOutput({tag, "_instr"}, bus.out_instr, instr);
      checkOutput({tag, "_err"}, 32'(bus.out_err), 32'(err));
      checkOutput({tag, "_addr"}, bus.out_addr, addr);
   endtask

   task automatic pulseStart();
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      checks        = 0;
      errors        = 0;
      rst           = 1'b1;
      bus.start     = 1'b0;
      bus.out_ready = 1'b1;
      applyStimulus(3'd0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0, 32'h0);
      idle();

      #3;
      checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("rst_out_instr", bus.out_instr, 32'h0);
      checkOutput("rst_out_err", 32'(bus.out_err), 32'd0);
      checkOutput("rst_out_addr", bus.out_addr, 32'h0);
      checkOutput("rst_err_count", 32'(bus.err_count), 32'd0);
      checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // addi x1,x0,5 and its two-cycle latency
      @(negedge clk); applyStimulus(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'd5);
      @(negedge clk); idle(); checkOutput("addi_lat1_valid", 32'(bus.out_valid), 32'd0);
      @(negedge clk); checkWord("addi", 32'h0050_0093, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("addi_drain_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("addi_next_addr", bus.out_addr, 32'h4);
      pulseStart();
      checkOutput("start_addr", bus.out_addr, 32'h0);

      // sw / beq and jal / lui back-to-back
      @(negedge clk); applyStimulus(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h0, 32'd8);
      @(negedge clk); applyStimulus(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0, -32'sd4);
      @(negedge clk); idle(); checkWord("sw", 32'h0020_A423, 1'b0, 32'h0);
      @(negedge clk); checkWord("beq", 32'hFE00_0EE3, 1'b0, 32'h4);
      @(negedge clk); applyStimulus(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'd2048);
      @(negedge clk); applyStimulus(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h0, 32'h1234_5000);
      @(negedge clk); idle(); checkWord("jal", 32'h0010_00EF, 1'b0, 32'h8);
      @(negedge clk); checkWord("lui", 32'h1234_52B7, 1'b0, 32'hC);
      @(negedge clk);
      checkOutput("ok_drain_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("ok_err_count", 32'(bus.err_count), 32'd0);
      pulseStart();

      // out-of-range immediates and illegal format
      @(negedge clk); applyStimulus(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'd2048);
      @(negedge clk); applyStimulus(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0, 32'd3);
      @(negedge clk); applyStimulus(3'd4, 7'h37, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0, 32'h0000_1001);
      checkWord("err_i", 32'h8000_0093, 1'b1, 32'h0);
      @(negedge clk); applyStimulus(3'd7, 7'h33, 5'd3, 5'd4, 5'd5, 3'd1, 7'h20, 32'h0);
      checkWord("err_b", 32'h0000_0163, 1'b1, 32'h4);
      @(negedge clk); idle(); checkWord("err_u", 32'h0000_1037, 1'b1, 32'h8);
      @(negedge clk); checkWord("err_fmt7", 32'h0000_0013, 1'b1, 32'hC);
      @(negedge clk);
      checkOutput("err_drain_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("err_count_4", 32'(bus.err_count), 32'd4);

      // 300 more errored words saturate the 8-bit counter
      for (int i = 0; i < 300; i++) begin
         @(negedge clk); applyStimulus(3'd6, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0, 32'h0);
      end
      @(negedge clk); idle();
      repeat (3) @(negedge clk);
      checkOutput("sat_drain_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("sat_err_count", 32'(bus.err_count), 32'd255);
      pulseStart();
      checkOutput("start_clr_count", 32'(bus.err_count), 32'd0);

      // backpressure: out_ready low while three words are offered
      bus.out_ready = 1'b0;
      @(negedge clk); applyStimulus(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'h0, 32'd1);
      @(negedge clk); checkOutput("bp_ready_a", 32'(bus.in_ready), 32'd1);
      applyStimulus(3'd1, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'h0, 32'd2);
      @(negedge clk); checkOutput("bp_ready_b", 32'(bus.in_ready), 32'd0);
      applyStimulus(3'd1, 7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 7'h0, 32'd3);
      checkWord("bp_a_first", 32'h0010_0113, 1'b0, 32'h0);
      @(negedge clk); checkOutput("bp_ready_c", 32'(bus.in_ready), 32'd0);
      checkWord("bp_a_hold1", 32'h0010_0113, 1'b0, 32'h0);
      @(negedge clk); checkWord("bp_a_hold2", 32'h0010_0113, 1'b0, 32'h0);
      bus.out_ready = 1'b1;
      #1 checkOutput("bp_ready_release", 32'(bus.in_ready), 32'd1);
      @(negedge clk); idle(); checkWord("bp_b", 32'h0020_0193, 1'b0, 32'h4);
      @(negedge clk); checkWord("bp_c", 32'h0030_0213, 1'b0, 32'h8);
      @(negedge clk); checkOutput("bp_drain_valid", 32'(bus.out_valid), 32'd0);
      pulseStart();

      // start coincides with the handshake of an errored word at address 8
      @(negedge clk); applyStimulus(3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h00, 32'h0);
      @(negedge clk); applyStimulus(3'd0, 7'h33, 5'd5, 5'd6, 5'd7, 3'd0, 7'h20, 32'h0);
      @(negedge clk); applyStimulus(3'd6, 7'h33, 5'd1, 5'd1, 5'd1, 3'd0, 7'h00, 32'h0);
      checkWord("st_w0", 32'h0031_00B3, 1'b0, 32'h0);
      @(negedge clk); applyStimulus(3'd1, 7'h13, 5'd6, 5'd0, 5'd0, 3'd0, 7'h0, 32'hFFFF_FFFF);
      checkWord("st_w1", 32'h4073_02B3, 1'b0, 32'h4);
      @(negedge clk); idle(); checkWord("st_w2", 32'h0000_0013, 1'b1, 32'h8);
      bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
      checkWord("st_w3", 32'hFFF0_0313, 1'b0, 32'h0);
      checkOutput("st_err_count", 32'(bus.err_count), 32'd0);
      @(negedge clk);
      checkOutput("st_drain_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("st_next_addr", bus.out_addr, 32'h4);

      // reset asserted with both stages occupied
      bus.out_ready = 1'b0;
      @(negedge clk); applyStimulus(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'h0, 32'd1);
      @(negedge clk); applyStimulus(3'd1, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'h0, 32'd2);
      @(negedge clk); idle(); checkWord("mr_before", 32'h0010_0113, 1'b0, 32'h4);
      rst = 1'b1;
      #1;
      checkOutput("mr_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("mr_addr", bus.out_addr, 32'h0);
      checkOutput("mr_instr", bus.out_instr, 32'h0);
      checkOutput("mr_in_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk); rst = 1'b0; bus.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("mr_dropped_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("mr_dropped_addr", bus.out_addr, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
